// File: rtl/exe_stage_if.sv
// exe_stage_if: ID/EX fields into, and EX/MEM fields out of, the execute stage.
// master = ID side (drives ID/EX fields); slave = exe_stage. Optional FORWARDING_EN.
interface exe_stage_if #(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 4
);
  logic                 freeze;
  logic                 imm;
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic                 wb_en;
  logic                 b;
  logic                 s;
  logic [3:0]           exe_cmd;
  logic [RF_ADDR_W-1:0] dest;
  logic [3:0]           status_reg;
  logic [11:0]          shift_operand;
  logic [23:0]          signed_imm_24;
  logic [DATA_W-1:0]    pc;
  logic [DATA_W-1:0]    val_rn;
  logic [DATA_W-1:0]    val_rm;
`ifdef FORWARDING_EN
  logic [1:0]           sel_src1;
  logic [1:0]           sel_src2;
  logic [DATA_W-1:0]    mem_fwd_val;
  logic [DATA_W-1:0]    wb_fwd_val;
`endif
  logic                 branch_taken;
  logic [DATA_W-1:0]    branch_addr;
  logic [3:0]           status_out;
  logic [DATA_W-1:0]    alu_res_o;
  logic [DATA_W-1:0]    val_rm_o;
  logic [RF_ADDR_W-1:0] dest_o;
  logic                 wb_en_o;
  logic                 mem_r_en_o;
  logic                 mem_w_en_o;

  modport master (
    output freeze, imm, mem_r_en, mem_w_en, wb_en, b, s,
    output exe_cmd, dest, status_reg, shift_operand,
    output signed_imm_24, pc, val_rn, val_rm,
`ifdef FORWARDING_EN
    output sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
`endif
    input  branch_taken, branch_addr, status_out,
    input  alu_res_o, val_rm_o, dest_o,
    input  wb_en_o, mem_r_en_o, mem_w_en_o
  );

  modport slave (
    input  freeze, imm, mem_r_en, mem_w_en, wb_en, b, s,
    input  exe_cmd, dest, status_reg, shift_operand,
    input  signed_imm_24, pc, val_rn, val_rm,
`ifdef FORWARDING_EN
    input  sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
`endif
    output branch_taken, branch_addr, status_out,
    output alu_res_o, val_rm_o, dest_o,
    output wb_en_o, mem_r_en_o, mem_w_en_o
  );
endinterface

// File: rtl/exe_stage.sv
// exe_stage: ARM execute stage - Val2 generation, ALU, NZCV register,
// branch target and EX/MEM register. Ports: clk, rst (async, active-high),
// bus (exe_stage_if.slave). Optional macro FORWARDING_EN adds Rn/Rm muxes.
module exe_stage #(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);
  logic [31:0] w_rn;
  logic [31:0] w_rm;

`ifdef FORWARDING_EN
  always_comb begin
    case (bus.sel_src1)
      2'b01:   w_rn = bus.mem_fwd_val;
      2'b10:   w_rn = bus.wb_fwd_val;
      default: w_rn = bus.val_rn;
    endcase
  end

  always_comb begin
    case (bus.sel_src2)
      2'b01:   w_rm = bus.mem_fwd_val;
      2'b10:   w_rm = bus.wb_fwd_val;
      default: w_rm = bus.val_rm;
    endcase
  end
`else
  assign w_rn = bus.val_rn;
  assign w_rm = bus.val_rm;
`endif

  // Rotations use a doubled word so a zero amount needs no special case.
  logic [4:0]  w_sh_amt;
  logic [4:0]  w_rot_amt;
  logic [63:0] w_imm_dbl;
  logic [63:0] w_imm_rot;
  logic [63:0] w_rm_rot;
  logic [31:0] w_val2;

  assign w_sh_amt  = bus.shift_operand[11:7];
  assign w_rot_amt = {bus.shift_operand[11:8], 1'b0};
  assign w_imm_dbl = {2{24'b0, bus.shift_operand[7:0]}};
  assign w_imm_rot = w_imm_dbl >> w_rot_amt;
  assign w_rm_rot  = {w_rm, w_rm} >> w_sh_amt;

  always_comb begin
    w_val2 = w_rm;
    if (bus.mem_r_en || bus.mem_w_en) begin
      w_val2 = {{20{bus.shift_operand[11]}}, bus.shift_operand};
    end else if (bus.imm) begin
      w_val2 = w_imm_rot[31:0];
    end else begin
      case (bus.shift_operand[6:5])
        2'b00:   w_val2 = w_rm << w_sh_amt;
        2'b01:   w_val2 = w_rm >> w_sh_amt;
        2'b10:   w_val2 = $unsigned($signed(w_rm) >>> w_sh_amt);
        default: w_val2 = w_rm_rot[31:0];
      endcase
    end
  end

  logic        w_cin;
  logic [32:0] w_sum;
  logic [31:0] w_res;
  logic        w_c;
  logic        w_v;
  logic        w_n;
  logic        w_z;

  assign w_cin = bus.status_reg[1];

  // Subtraction is Rn + ~Val2 + carry-in, so carry out is NOT borrow.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.exe_cmd)
      4'b0001: w_res = w_val2;
      4'b1001: w_res = ~w_val2;
      4'b0010, 4'b0011: begin
        w_sum = {1'b0, w_rn} + {1'b0, w_val2}
              + {32'b0, (bus.exe_cmd[0] & w_cin)};
        w_res = w_sum[31:0];
        w_c   = w_sum[32];
        w_v   = (w_rn[31] == w_val2[31]) &&
                (w_res[31] != w_rn[31]);
      end
      4'b0100, 4'b0101: begin
        w_sum = {1'b0, w_rn} + {1'b0, ~w_val2}
              + {32'b0, (bus.exe_cmd[0] ? w_cin : 1'b1)};
        w_res = w_sum[31:0];
        w_c   = w_sum[32];
        w_v   = (w_rn[31] != w_val2[31]) &&
                (w_res[31] != w_rn[31]);
      end
      4'b0110: w_res = w_rn & w_val2;
      4'b0111: w_res = w_rn | w_val2;
      4'b1000: w_res = w_rn ^ w_val2;
      default: w_res = '0;
    endcase
  end

  assign w_n = w_res[31];
  assign w_z = (w_res == 32'd0);

  assign bus.branch_taken = bus.b;
  assign bus.branch_addr  = bus.pc +
    {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};

  logic [3:0]           r_status;
  logic [31:0]          r_alu_res;
  logic [31:0]          r_val_rm;
  logic [RF_ADDR_W-1:0] r_dest;
  logic                 r_wb_en;
  logic                 r_mem_r_en;
  logic                 r_mem_w_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= '0;
    end else if (bus.s && !bus.freeze) begin
      r_status <= {w_n, w_z, w_c, w_v};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_res  <= '0;
      r_val_rm   <= '0;
      r_dest     <= '0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
    end else if (!bus.freeze) begin
      r_alu_res  <= w_res;
      r_val_rm   <= w_rm;
      r_dest     <= bus.dest;
      r_wb_en    <= bus.wb_en;
      r_mem_r_en <= bus.mem_r_en;
      r_mem_w_en <= bus.mem_w_en;
    end
  end

  assign bus.status_out = r_status;
  assign bus.alu_res_o  = r_alu_res;
  assign bus.val_rm_o   = r_val_rm;
  assign bus.dest_o     = r_dest;
  assign bus.wb_en_o    = r_wb_en;
  assign bus.mem_r_en_o = r_mem_r_en;
  assign bus.mem_w_en_o = r_mem_w_en;
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline; consumes every field the ID/EX pipeline register presents.
- Combinationally: generates Val2, runs the ALU and computes the branch target.
- Sequentially: holds the NZCV status register and the EX/MEM output register.
- Drives the branch flush back to IF/ID and publishes status flags to ID for condition checking.

Parameters:
- DATA_W, 32, datapath width (only 32 supported).
- RF_ADDR_W, 4, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  hold EX/MEM register and status register (memory wait)
- imm  in  1  operand2 is rotated immediate
- mem_r_en  in  1  load
- mem_w_en  in  1  store
- wb_en  in  1  writeback enable
- b  in  1  branch
- s  in  1  update flags
- exe_cmd  in  4  ALU opcode
- dest  in  4  destination register
- status_reg  in  4  NZCV snapshot captured in ID
- shift_operand  in  12  operand2 field
- signed_imm_24  in  24  branch offset
- pc  in  32  PC+4 of instruction
- val_rn  in  32  Rn value
- val_rm  in  32  Rm value
- branch_taken  out  1  flush request (combinational)
- branch_addr  out  32  branch target (combinational)
- status_out  out  4  NZCV register
- alu_res_o  out  32  registered ALU result
- val_rm_o  out  32  registered store data
- dest_o  out  4  registered destination
- wb_en_o  out  1  registered
- mem_r_en_o  out  1  registered
- mem_w_en_o  out  1  registered

Behaviour:
- Reset: all registered outputs and status_out go to 0 immediately on rst.
- Val2 selection:
  - mem_r_en or mem_w_en: sign-extend shift_operand[11:0].
  - Else if imm: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - Else: val_rm shifted by shift_operand[11:7] using type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes val_rm unchanged.
- ALU, using C = status_reg[1]:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2
  - 0011 ADC: Rn+Val2+C
  - 0100 SUB: Rn-Val2
  - 0101 SBC: Rn-Val2-!C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - Any other opcode: result 0, flags N/Z from the 0 result, C=V=0.
- Flags:
  - N = res[31]; Z = (res==0).
  - C = carry out of the 33-bit add for ADD/ADC; for SUB/SBC, C = NOT borrow. C=0 for logical ops and MOV/MVN.
  - V = signed overflow for add/sub family; 0 otherwise.
- Status register: on posedge, if s && !freeze, load {N,Z,C,V}; else hold.
- Branch:
  - branch_taken = b.
  - branch_addr = pc + (sign_extend(signed_imm_24) << 2), modulo 2^32.
  - Both are combinational, zero-latency, and valid in the same cycle b is high.
- EX/MEM register: on posedge, if !freeze, capture alu_res, val_rm, dest, wb_en, mem_r_en, mem_w_en; else hold all. Latency = 1 cycle.
- Freeze and b together: branch_taken still asserts (the flush takes priority upstream); registers hold.
- Reset mid-operation overrides freeze and any pending update.

Optional Feature:
- Macro FORWARDING_EN.
- Defined:
  - Adds inputs sel_src1[1:0], sel_src2[1:0], mem_fwd_val[31:0], wb_fwd_val[31:0].
  - Select encoding: 00 register value, 01 mem_fwd_val, 10 wb_fwd_val, 11 treated as 00.
  - Rn for the ALU and Rm (for both shift and store data) are taken through these muxes.
- Undefined: ports absent; val_rn and val_rm are used directly.

Test Plan:
- ADD, exe_cmd=0010, val_rn=0xFFFFFFFF, imm=1, shift_operand=0x001, s=1 -> next cycle alu_res_o=0, status_out=0110 (Z,C).
- SUB with V set, val_rn=0x80000000, Val2=1 (imm), s=1 -> alu_res_o=0x7FFFFFFF, status_out=0011 (C=1, V=1).
- LSL by 4 (imm=0, shift_operand=0x200), val_rm=0x0000000F, MOV -> alu_res_o=0x000000F0; same with ROR by 4 (shift_operand=0x260), val_rm=0x0000000F -> 0xF0000000.
- Store, mem_w_en=1, exe_cmd=0010, val_rn=0x100, shift_operand=0xFFC -> alu_res_o=0x0FC, val_rm_o=val_rm, mem_w_en_o=1.
- Branch, b=1, pc=0x20, signed_imm_24=0xFFFFFE -> branch_taken=1 same cycle, branch_addr=0x18.
- freeze=1 for 3 cycles while inputs change, s=1 -> registered outputs and status_out unchanged; assert rst mid-freeze -> all outputs 0.
